// File: rtl/useq_pkg.sv
// useq_pkg: shared definitions for the microprogram sequencer.
//   - SEQ_* : next-address sequencing codes held in the microword seq field
//   - state_t : sequencer run state
//   - field helpers : microword width and field positions from UADDR_W/SEL_W
package useq_pkg;

  localparam logic [1:0] SEQ_NEXT  = 2'b00;
  localparam logic [1:0] SEQ_COND  = 2'b01;
  localparam logic [1:0] SEQ_DISP  = 2'b10;
  localparam logic [1:0] SEQ_FETCH = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Microword = {seq[1:0], sel[SEL_W-1:0], addr[UADDR_W-1:0]}
  function automatic int unsigned uw_width(int unsigned uaddr_w, int unsigned sel_w);
    return 2 + sel_w + uaddr_w;
  endfunction

  function automatic int unsigned sel_lsb(int unsigned uaddr_w);
    return uaddr_w;
  endfunction

  function automatic int unsigned seq_lsb(int unsigned uaddr_w, int unsigned sel_w);
    return uaddr_w + sel_w;
  endfunction

endpackage

// File: rtl/useq_if.sv
// useq_if: sequencer bus bundle.
//   master : drives start/stop/cond/disp_addr/ld_* (and hold when USEQ_HOLD_EN)
//            and observes strobe/upc/running/ld_err
//   slave  : the sequencer side of the same signals
// Macro USEQ_HOLD_EN adds the hold stall signal.
interface useq_if #(
  parameter int unsigned UADDR_W  = 4,
  parameter int unsigned N_STROBE = 6
);
  import useq_pkg::*;

  localparam int unsigned SEL_W = $clog2(N_STROBE + 1);
  localparam int unsigned UW    = uw_width(UADDR_W, SEL_W);

  logic                start;
  logic                stop;
  logic                cond;
  logic [UADDR_W-1:0]  disp_addr;
  logic                ld_en;
  logic [UADDR_W-1:0]  ld_addr;
  logic [UW-1:0]       ld_data;
`ifdef USEQ_HOLD_EN
  logic                hold;
`endif
  logic [N_STROBE-1:0] strobe;
  logic [UADDR_W-1:0]  upc;
  logic                running;
  logic                ld_err;

  modport master (
    output start, stop, cond, disp_addr, ld_en, ld_addr, ld_data,
`ifdef USEQ_HOLD_EN
    output hold,
`endif
    input  strobe, upc, running, ld_err
  );

  modport slave (
    input  start, stop, cond, disp_addr, ld_en, ld_addr, ld_data,
`ifdef USEQ_HOLD_EN
    input  hold,
`endif
    output strobe, upc, running, ld_err
  );

endinterface

// File: rtl/useq_decode.sv
// useq_decode: sel-to-one-hot strobe decoder, purely combinational.
//   i_sel    : strobe-select field; k in 1..N_STROBE sets o_strobe[k-1]
//   i_en     : when low the output is all zero
//   o_strobe : one-hot (or zero) control vector
module useq_decode #(
  parameter int unsigned N_STROBE = 6,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_en,
  output logic [N_STROBE-1:0] o_strobe
);

  // sel=0 and out-of-range codes match no k and leave the vector zero
  always_comb begin
    o_strobe = '0;
    for (int unsigned k = 1; k <= N_STROBE; k++) begin
      if (i_en && (i_sel == SEL_W'(k))) begin
        o_strobe[k-1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer with writable control store.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (control store is not reset)
//   bus  : useq_if.slave - start/stop/cond/disp_addr/ld_en/ld_addr/ld_data in,
//          strobe/upc/running/ld_err out
// Macro USEQ_HOLD_EN: adds bus.hold, which in RUN freezes upc and zeroes strobe.
module useq_ctrl
  import useq_pkg::*;
#(
  parameter int unsigned UADDR_W  = 4,
  parameter int unsigned N_STROBE = 6
) (
  input logic     clk,
  input logic     rst,
  useq_if.slave   bus
);

  localparam int unsigned SEL_W   = $clog2(N_STROBE + 1);
  localparam int unsigned UW      = uw_width(UADDR_W, SEL_W);
  localparam int unsigned DEPTH   = 2 ** UADDR_W;
  localparam int unsigned SEL_LSB = sel_lsb(UADDR_W);
  localparam int unsigned SEQ_LSB = seq_lsb(UADDR_W, SEL_W);

  state_t             r_state;
  logic [UADDR_W-1:0] r_upc;
  logic               r_ld_err;
  logic [UW-1:0]      r_store [DEPTH];

  logic [UW-1:0]      w_word;
  logic [1:0]         w_seq;
  logic [SEL_W-1:0]   w_sel;
  logic [UADDR_W-1:0] w_addr;
  logic [UADDR_W-1:0] w_upc_inc;
  logic [UADDR_W-1:0] w_next;
  logic               w_run;
  logic               w_hold;

`ifdef USEQ_HOLD_EN
  assign w_hold = bus.hold;
`else
  assign w_hold = 1'b0;
`endif

  // Current microword fields
  assign w_word    = r_store[r_upc];
  assign w_seq     = w_word[SEQ_LSB +: 2];
  assign w_sel     = w_word[SEL_LSB +: SEL_W];
  assign w_addr    = w_word[UADDR_W-1:0];
  assign w_run     = (r_state == ST_RUN);
  assign w_upc_inc = r_upc + UADDR_W'(1);

  // Next-address mux; increment wraps naturally at DEPTH-1
  always_comb begin
    w_next = w_upc_inc;
    case (w_seq)
      SEQ_NEXT:  w_next = w_upc_inc;
      SEQ_COND:  w_next = bus.cond ? w_addr : w_upc_inc;
      SEQ_DISP:  w_next = bus.disp_addr;
      SEQ_FETCH: w_next = '0;
      default:   w_next = w_upc_inc;
    endcase
  end

  // Control store: written only while idle, never reset
  always_ff @(posedge clk) begin
    if (bus.ld_en && (r_state == ST_IDLE)) begin
      r_store[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Run-state FSM, micro-PC and write-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_upc    <= '0;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= bus.ld_en && (r_state == ST_RUN);
      case (r_state)
        ST_IDLE: begin
          r_upc <= '0;
          if (bus.start) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_upc   <= '0;
          end else if (!w_hold) begin
            r_upc <= w_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_upc   <= '0;
        end
      endcase
    end
  end

  useq_decode #(
    .N_STROBE (N_STROBE),
    .SEL_W    (SEL_W)
  ) u_decode (
    .i_sel    (w_sel),
    .i_en     (w_run && !w_hold),
    .o_strobe (bus.strobe)
  );

  assign bus.upc     = r_upc;
  assign bus.running = w_run;
  assign bus.ld_err  = r_ld_err;

endmodule

// File: tb/tb_useq_ctrl.sv
// tb_useq_ctrl: table-driven check of useq_ctrl (UADDR_W=4, N_STROBE=6, UW=9)
// plus hand sequences for asynchronous reset and, with USEQ_HOLD_EN, hold.
module tb_useq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  useq_if #(.UADDR_W(4), .N_STROBE(6)) bus ();

  useq_ctrl #(.UADDR_W(4), .N_STROBE(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Control-store image: 0 NEXT sel6, 1 COND sel1 ->5, 2 DISP, 5 FETCH sel5,
  // A NEXT sel7 (out of range -> zero strobe), everything else NEXT sel0.
  localparam logic [8:0] IMG [16] = '{
    9'h060, 9'h095, 9'h100, 9'h000, 9'h000, 9'h1D0, 9'h000, 9'h000,
    9'h000, 9'h000, 9'h070, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000
  };

  typedef struct {
    logic       start;
    logic       stop;
    logic       cond;
    logic [3:0] disp;
    logic       ld_en;
    logic [3:0] ld_addr;
    logic [8:0] ld_data;
    logic [3:0] e_upc;
    logic [5:0] e_strobe;
    logic       e_run;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic sp, logic c, logic [3:0] d,
                              logic le, logic [3:0] la, logic [8:0] ldd,
                              logic [3:0] eu, logic [5:0] es, logic er, logic ee);
    vec_t v;
    v.start = st; v.stop = sp; v.cond = c; v.disp = d;
    v.ld_en = le; v.ld_addr = la; v.ld_data = ldd;
    v.e_upc = eu; v.e_strobe = es; v.e_run = er; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare {upc, strobe, running, ld_err} as one record
  task automatic chk_out(input string name, input logic [3:0] eu, input logic [5:0] es,
                         input logic er, input logic ee);
    chk(name, 32'({bus.upc, bus.strobe, bus.running, bus.ld_err}), 32'({eu, es, er, ee}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.stop = 1'b0; bus.cond = 1'b0; bus.disp_addr = 4'h0;
    bus.ld_en = 1'b0; bus.ld_addr = 4'h0; bus.ld_data = 9'h000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    drive_idle();
`ifdef USEQ_HOLD_EN
    bus.hold = 1'b0;
`endif

    #12;
    chk_out("reset_values", 4'h0, 6'b000000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Load the image while idle
    for (int a = 0; a < 16; a++) begin
      bus.ld_en = 1'b1; bus.ld_addr = 4'(a); bus.ld_data = IMG[a];
      step();
    end
    bus.ld_en = 1'b0;
    chk_out("idle_after_load", 4'h0, 6'b000000, 1'b0, 1'b0);

    //              st sp c  disp  le la    data     upc    strobe      run err
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b100000, 1, 0)); // start
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h1, 6'b000001, 1, 0)); // NEXT
    vecs.push_back(mk(0, 0, 1, 4'h0, 0, 4'h0, 9'h000, 4'h5, 6'b010000, 1, 0)); // COND taken
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b100000, 1, 0)); // FETCH
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h1, 6'b000001, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h2, 6'b000000, 1, 0)); // COND not taken
    vecs.push_back(mk(0, 0, 0, 4'hA, 0, 4'h0, 9'h000, 4'hA, 6'b000000, 1, 0)); // DISP, sel7
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'hB, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'hC, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'hD, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'hE, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'hF, 6'b000000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b100000, 1, 0)); // wrap
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 4'h0, 9'h1FF, 4'h1, 6'b000001, 1, 1)); // write in RUN
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h2, 6'b000000, 1, 0)); // err clears, start ignored
    vecs.push_back(mk(0, 1, 0, 4'h3, 0, 4'h0, 9'h000, 4'h0, 6'b000000, 0, 0)); // stop
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b000000, 0, 0)); // stop in IDLE
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b100000, 1, 0)); // word0 intact
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h1, 6'b000001, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b000000, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 1, 4'h0, 9'h050, 4'h0, 6'b010000, 1, 0)); // load+start
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 9'h000, 4'h1, 6'b000001, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 9'h000, 4'h0, 6'b000000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 1, 4'h0, 9'h060, 4'h0, 6'b000000, 0, 0)); // restore word0

    foreach (vecs[i]) begin
      bus.start = vecs[i].start; bus.stop = vecs[i].stop; bus.cond = vecs[i].cond;
      bus.disp_addr = vecs[i].disp; bus.ld_en = vecs[i].ld_en;
      bus.ld_addr = vecs[i].ld_addr; bus.ld_data = vecs[i].ld_data;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_upc, vecs[i].e_strobe,
              vecs[i].e_run, vecs[i].e_err);
    end
    drive_idle();

    // Asynchronous reset mid-RUN at upc=5, then replay
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk_out("rst_pre0", 4'h0, 6'b100000, 1'b1, 1'b0);
    step();
    bus.cond = 1'b1; step(); bus.cond = 1'b0;
    chk_out("rst_pre5", 4'h5, 6'b010000, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_out("rst_async", 4'h0, 6'b000000, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk_out("replay0", 4'h0, 6'b100000, 1'b1, 1'b0);
    step();
    chk_out("replay1", 4'h1, 6'b000001, 1'b1, 1'b0);
    bus.cond = 1'b1; step(); bus.cond = 1'b0;
    chk_out("replay5", 4'h5, 6'b010000, 1'b1, 1'b0);
    step();
    chk_out("replay_fetch", 4'h0, 6'b100000, 1'b1, 1'b0);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
    chk_out("replay_stop", 4'h0, 6'b000000, 1'b0, 1'b0);

`ifdef USEQ_HOLD_EN
    // Hold freezes upc at 1 and blanks strobe; stop still wins under hold
    bus.start = 1'b1; step(); bus.start = 1'b0;
    step();
    chk_out("hold_pre", 4'h1, 6'b000001, 1'b1, 1'b0);
    bus.hold = 1'b1; bus.cond = 1'b1;
    #1;
    chk_out("hold_comb", 4'h1, 6'b000000, 1'b1, 1'b0);
    for (int h = 0; h < 3; h++) begin
      step();
      chk_out($sformatf("hold%0d", h), 4'h1, 6'b000000, 1'b1, 1'b0);
    end
    bus.hold = 1'b0;
    #1;
    chk_out("hold_release", 4'h1, 6'b000001, 1'b1, 1'b0);
    step(); bus.cond = 1'b0;
    chk_out("hold_resume", 4'h5, 6'b010000, 1'b1, 1'b0);
    bus.hold = 1'b1; bus.stop = 1'b1; step(); bus.stop = 1'b0; bus.hold = 1'b0;
    chk_out("hold_stop", 4'h0, 6'b000000, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
